// File: rtl/mips_cpu_bus_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_lsu_if
// Brief    : CPU request/response channel plus Avalon-style data-bus signals
//            of the load/store unit. "master" is the LSU side.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_cpu_bus_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       req_rt;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
        output req_ready, resp_valid, resp_data, resp_err,
               address, read, write, byteenable, writedata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rt, waitrequest, readdata,
        input  req_ready, resp_valid, resp_data, resp_err,
               address, read, write, byteenable, writedata
    );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_bus_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus_lsu
// Brief    : MIPS load/store unit; one CPU memory op becomes one word-aligned
//            Avalon-style bus transfer with byte lanes and load formatting.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_cpu_bus_lsu_if.master bus
);

    localparam logic [3:0] C_OP_LB  = 4'd0;
    localparam logic [3:0] C_OP_LBU = 4'd1;
    localparam logic [3:0] C_OP_LH  = 4'd2;
    localparam logic [3:0] C_OP_LHU = 4'd3;
    localparam logic [3:0] C_OP_LW  = 4'd4;
    localparam logic [3:0] C_OP_LWL = 4'd5;
    localparam logic [3:0] C_OP_LWR = 4'd6;
    localparam logic [3:0] C_OP_SB  = 4'd8;
    localparam logic [3:0] C_OP_SH  = 4'd9;
    localparam logic [3:0] C_OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_op;
    logic [1:0]        r_k;
    logic [31:0]       r_rt;
    logic              r_err;
    logic [ADDR_W-1:0] r_address;
    logic              r_read;
    logic              r_write;
    logic [3:0]        r_byteenable;
    logic [31:0]       r_writedata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_data;
    logic              r_resp_err;

    logic              w_err;
    logic              w_store;
    logic [3:0]        w_be;
    logic [31:0]       w_wd;
    logic [31:0]       w_shr;
    logic [31:0]       w_load;

    // Request decode: legality, direction, lane mask and replicated store data.
    always_comb begin
        w_err   = 1'b0;
        w_store = 1'b0;
        w_be    = 4'b1111;
        w_wd    = 32'h0;
        case (bus.req_op)
            C_OP_LB, C_OP_LBU: begin
                w_be = 4'b0001 << bus.req_addr[1:0];
            end
            C_OP_LH, C_OP_LHU: begin
                w_err = bus.req_addr[0];
                w_be  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            C_OP_LW: begin
                w_err = |bus.req_addr[1:0];
            end
            C_OP_LWL, C_OP_LWR: begin
                w_be = 4'b1111;
            end
            C_OP_SB: begin
                w_store = 1'b1;
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wd    = {4{bus.req_wdata[7:0]}};
            end
            C_OP_SH: begin
                w_store = 1'b1;
                w_err   = bus.req_addr[0];
                w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wd    = {2{bus.req_wdata[15:0]}};
            end
            C_OP_SW: begin
                w_store = 1'b1;
                w_err   = |bus.req_addr[1:0];
                w_wd    = bus.req_wdata;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Load formatting; LWL/LWR keep the untouched bytes of the old rt value.
    always_comb begin
        w_shr  = bus.readdata >> {r_k, 3'b000};
        w_load = bus.readdata;
        case (r_op)
            C_OP_LB:  w_load = {{24{w_shr[7]}}, w_shr[7:0]};
            C_OP_LBU: w_load = {24'h0, w_shr[7:0]};
            C_OP_LH:  w_load = {{16{w_shr[15]}}, w_shr[15:0]};
            C_OP_LHU: w_load = {16'h0, w_shr[15:0]};
            C_OP_LWL: w_load = (bus.readdata << {~r_k, 3'b000})
                             | (r_rt & ~(32'hFFFF_FFFF << {~r_k, 3'b000}));
            C_OP_LWR: w_load = w_shr | (r_rt & ~(32'hFFFF_FFFF >> {r_k, 3'b000}));
            default:  w_load = bus.readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 4'h0;
            r_k          <= 2'b00;
            r_rt         <= 32'h0;
            r_err        <= 1'b0;
            r_address    <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_byteenable <= 4'h0;
            r_writedata  <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_op    <= bus.req_op;
                        r_k     <= bus.req_addr[1:0];
                        r_rt    <= bus.req_rt;
                        r_err   <= w_err;
                        r_state <= S_ISSUE;
                        if (!w_err) begin
                            r_address    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            r_byteenable <= w_be;
                            r_writedata  <= w_wd;
                            r_read       <= ~w_store;
                            r_write      <= w_store;
                        end
                    end
                end
                S_ISSUE: begin
                    // Rejected ops spend one bus-less cycle here so errors share store latency.
                    if (r_err) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= 32'h0;
                        r_resp_err   <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (!bus.waitrequest) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        if (r_write) begin
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= 32'h0;
                            r_resp_err   <= 1'b0;
                            r_state      <= S_RESP;
                        end else begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= w_load;
                    r_resp_err   <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign bus.address    = r_address;
    assign bus.read       = r_read;
    assign bus.write      = r_write;
    assign bus.byteenable = r_byteenable;
    assign bus.writedata  = r_writedata;

endmodule
`default_nettype wire
